// File: rtl/life_board_scan_ctrl.sv
// Game of Life board controller: loads preset patterns from ROM into the row-wide
// board RAM and scans the board out as square pixel cells for the VGA plotter.
module life_board_scan_ctrl #(
  parameter int unsigned COLS    = 40,
  parameter int unsigned ROWS    = 30,
  parameter int unsigned CELL_LG = 2,
  parameter int unsigned NPRESET = 6,
  localparam int unsigned RAW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned PIW  = (NPRESET > 1) ? $clog2(NPRESET) : 1,
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    draw_req,
  input  logic [NPRESET-1:0]      preset_req,
  output logic                    busy,
  output logic                    done,
  output logic [RAW-1:0]          ram_addr,
  output logic [COLS-1:0]         ram_wdata,
  output logic                    ram_wren,
  input  logic [COLS-1:0]         ram_rdata,
  output logic [PIW+RAW-1:0]      pat_addr,
  input  logic [COLS-1:0]         pat_rdata,
  output logic [CW+CELL_LG-1:0]   pix_x,
  output logic [RAW+CELL_LG-1:0]  pix_y,
  output logic                    pix_on,
  output logic                    plot
);

  localparam int unsigned SW   = 2 * CELL_LG;
  localparam int unsigned CNTW = RAW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, RD, LATCH, PIX, DONE} state_t;

  state_t            state, state_nx;
  logic              preset_pend, draw_pend;
  logic [PIW-1:0]    preset_idx, req_idx;
  logic [CNTW-1:0]   cnt;
  logic [RAW-1:0]    row;
  logic [CW-1:0]     col;
  logic [SW-1:0]     sub;
  logic [COLS-1:0]   rowbuf;
  logic              sub_last, col_last, row_last, load_last;

  assign sub_last  = &sub;
  assign col_last  = (col == CW'(COLS - 1));
  assign row_last  = (row == RAW'(ROWS - 1));
  // Load counter is one bit wider than a row address so it can rest at ROWS.
  assign load_last = (cnt == CNTW'(ROWS));

  assign pix_x = {col, sub[CELL_LG-1:0]};
  assign pix_y = {row, sub[SW-1:CELL_LG]};

  // Lowest set request bit wins.
  always_comb begin
    req_idx = '0;
    for (int i = int'(NPRESET) - 1; i >= 0; i--) begin
      if (preset_req[i]) req_idx = PIW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    ram_wren  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    pat_addr  = '0;
    plot      = 1'b0;
    pix_on    = 1'b0;
    unique case (state)
      IDLE: begin
        if (preset_pend)    state_nx = LOAD;
        else if (draw_pend) state_nx = RD;
      end
      LOAD: begin
        if (!load_last) pat_addr = {preset_idx, cnt[RAW-1:0]};
        // ROM data lags its address by one cycle, so writes trail by one row.
        if (cnt != '0) begin
          ram_wren  = 1'b1;
          ram_addr  = RAW'(cnt - CNTW'(1));
          ram_wdata = pat_rdata;
        end
        if (load_last) state_nx = DONE;
      end
      RD: begin
        ram_addr = row;
        state_nx = LATCH;
      end
      LATCH: begin
        ram_addr = row;
        state_nx = PIX;
      end
      PIX: begin
        plot   = 1'b1;
        pix_on = rowbuf[CW'(COLS - 1) - col];
        if (sub_last && col_last) state_nx = row_last ? DONE : RD;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latching and scan/load counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      preset_pend <= 1'b0;
      preset_idx  <= '0;
      draw_pend   <= 1'b0;
      cnt         <= '0;
      row         <= '0;
      col         <= '0;
      sub         <= '0;
      rowbuf      <= '0;
    end else begin
      if (!preset_pend && (|preset_req)) begin
        preset_pend <= 1'b1;
        preset_idx  <= req_idx;
      end else if (state == IDLE && state_nx == LOAD) begin
        preset_pend <= 1'b0;
      end
      if (draw_req)                                draw_pend <= 1'b1;
      else if (state == IDLE && state_nx == RD)    draw_pend <= 1'b0;

      case (state)
        LOAD: if (!load_last) cnt <= cnt + CNTW'(1);
        LATCH: begin
          rowbuf <= ram_rdata;
          col    <= '0;
          sub    <= '0;
        end
        PIX: begin
          sub <= sub + SW'(1);
          if (sub_last) begin
            if (col_last) begin
              col <= '0;
              row <= row_last ? '0 : row + RAW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_life_board_scan_ctrl.sv
// Bench for life_board_scan_ctrl: a default-size instance for preset loads and a
// 4x3 board with 2x2 cells for scans, checked against a pixel-list reference model.
module tb_life_board_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Small instance: COLS=4, ROWS=3, CELL_LG=1
  logic       s_draw, s_busy, s_done, s_wren, s_pix_on, s_plot;
  logic [5:0] s_preset;
  logic [1:0] s_ram_addr;
  logic [3:0] s_wdata, s_rdata, s_pat_rdata;
  logic [4:0] s_pat_addr;
  logic [2:0] s_pix_x, s_pix_y;

  // Default instance: COLS=40, ROWS=30, CELL_LG=2
  logic        b_draw, b_busy, b_done, b_wren, b_pix_on, b_plot;
  logic [5:0]  b_preset;
  logic [4:0]  b_ram_addr;
  logic [39:0] b_wdata, b_rdata, b_pat_rdata;
  logic [7:0]  b_pat_addr, b_pix_x;
  logic [6:0]  b_pix_y;

  life_board_scan_ctrl #(.COLS(4), .ROWS(3), .CELL_LG(1), .NPRESET(6)) u_small (
    .clk(clk), .reset(rst), .draw_req(s_draw), .preset_req(s_preset),
    .busy(s_busy), .done(s_done), .ram_addr(s_ram_addr), .ram_wdata(s_wdata),
    .ram_wren(s_wren), .ram_rdata(s_rdata), .pat_addr(s_pat_addr),
    .pat_rdata(s_pat_rdata), .pix_x(s_pix_x), .pix_y(s_pix_y),
    .pix_on(s_pix_on), .plot(s_plot));

  life_board_scan_ctrl u_big (
    .clk(clk), .reset(rst), .draw_req(b_draw), .preset_req(b_preset),
    .busy(b_busy), .done(b_done), .ram_addr(b_ram_addr), .ram_wdata(b_wdata),
    .ram_wren(b_wren), .ram_rdata(b_rdata), .pat_addr(b_pat_addr),
    .pat_rdata(b_pat_rdata), .pix_x(b_pix_x), .pix_y(b_pix_y),
    .pix_on(b_pix_on), .plot(b_plot));

  function automatic logic [3:0] rom_s(input int idx, input int r);
    return 4'((idx * 7 + r * 5 + 3) % 16);
  endfunction

  function automatic logic [39:0] rom_b(input int idx, input int r);
    return {8'hA5, 16'(idx), 16'(r)};
  endfunction

  // Board RAMs (registered read) and pattern ROMs (1-cycle latency)
  logic [3:0]  s_mem [3];
  logic [39:0] b_mem [30];
  logic        bd_we;
  logic [1:0]  bd_addr;
  logic [3:0]  bd_data;

  always @(posedge clk) begin
    if (bd_we) s_mem[bd_addr] <= bd_data;
    else if (s_wren && s_ram_addr < 2'd3) s_mem[s_ram_addr] <= s_wdata;
    s_rdata     <= (s_ram_addr < 2'd3) ? s_mem[s_ram_addr] : 4'h0;
    s_pat_rdata <= rom_s(int'(s_pat_addr[4:2]), int'(s_pat_addr[1:0]));
    if (b_wren && b_ram_addr < 5'd30) b_mem[b_ram_addr] <= b_wdata;
    b_rdata     <= (b_ram_addr < 5'd30) ? b_mem[b_ram_addr] : 40'h0;
    b_pat_rdata <= rom_b(int'(b_pat_addr[7:5]), int'(b_pat_addr[4:0]));
  end

  int checks = 0;
  int errors = 0;
  logic [3:0]  shadow [3];
  int          px_n, wr_n, cyc, ovl, nb;
  int          ax [64];
  int          ay [64];
  logic        aon [64];
  int          wa [64];
  logic [39:0] wd [64];

  typedef struct { logic [5:0] req; int idx; } load_vec_t;
  typedef struct { logic [3:0] r0, r1, r2; int ones; logic first_on; logic last_on; } scan_vec_t;
  load_vec_t lt [4];
  scan_vec_t st [4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_rows(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    logic [3:0] v [3];
    v[0] = r0; v[1] = r1; v[2] = r2;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 2'(j); bd_data = v[j];
      shadow[j] = v[j];
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic pulse_small(input logic [5:0] preq, input logic draw);
    @(negedge clk);
    s_preset = preq;
    s_draw   = draw;
  endtask

  // Runs until done; k counts negedges, inj_at optionally pulses requests mid-run.
  task automatic run_small(input int budget, input int inj_at, input logic [5:0] inj_p,
                           input logic inj_d);
    px_n = 0; wr_n = 0; cyc = -1; ovl = 0; nb = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (s_plot && s_wren) ovl++;
      if (s_busy && !s_done) nb++;
      if (s_plot) begin
        if (px_n < 64) begin
          ax[px_n] = int'(s_pix_x); ay[px_n] = int'(s_pix_y); aon[px_n] = s_pix_on;
        end
        px_n++;
      end
      if (s_wren) begin
        if (wr_n < 64) begin wa[wr_n] = int'(s_ram_addr); wd[wr_n] = 40'(s_wdata); end
        wr_n++;
      end
      s_preset = (k == inj_at) ? inj_p : 6'd0;
      s_draw   = (k == inj_at) ? inj_d : 1'b0;
      if (s_done) begin cyc = k; break; end
    end
    chk("small_done_seen", longint'(cyc >= 0), 1);
    chk("small_plot_wren_overlap", ovl, 0);
  endtask

  task automatic run_big(input int budget);
    wr_n = 0; cyc = -1; ovl = 0; nb = 0; px_n = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (b_plot && b_wren) ovl++;
      if (b_plot) px_n++;
      if (b_busy && !b_done) nb++;
      if (b_wren) begin
        if (wr_n < 64) begin wa[wr_n] = int'(b_ram_addr); wd[wr_n] = b_wdata; end
        wr_n++;
      end
      b_preset = 6'd0;
      if (b_done) begin cyc = k; break; end
    end
    chk("big_done_seen", longint'(cyc >= 0), 1);
    chk("big_plot_during_load", px_n + ovl, 0);
  endtask

  task automatic check_load_small(input string name, input int idx);
    int mism;
    mism = 0;
    chk({name, "_writes"}, wr_n, 3);
    chk({name, "_latency"}, cyc, 6);
    chk({name, "_busy_cycles"}, nb, 4);
    for (int j = 0; j < 3 && j < wr_n; j++)
      if (wa[j] != j || wd[j][3:0] != rom_s(idx, j)) mism++;
    chk({name, "_row_data"}, mism, 0);
    for (int j = 0; j < 3; j++) shadow[j] = rom_s(idx, j);
  endtask

  // Reference: every row, every cell left to right, each cell raster-ordered.
  task automatic check_scan(input string name);
    int mism, ones, exp_ones, i;
    logic eon;
    mism = 0; ones = 0; exp_ones = 0; i = 0;
    chk({name, "_plots"}, px_n, 48);
    chk({name, "_busy_cycles"}, nb, 54);
    chk({name, "_latency"}, cyc, 56);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        for (int py = 0; py < 2; py++)
          for (int px = 0; px < 2; px++) begin
            eon = shadow[r][3-c];
            if (eon) exp_ones++;
            if (i < px_n && i < 64)
              if (ax[i] != c * 2 + px || ay[i] != r * 2 + py || aon[i] !== eon) mism++;
            i++;
          end
    chk({name, "_pixels"}, mism, 0);
    for (int j = 0; j < px_n && j < 64; j++) if (aon[j]) ones++;
    chk({name, "_on_count"}, ones, exp_ones);
  endtask

  task automatic idle_quiet(input string name, input int n);
    int act;
    act = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (s_busy || s_plot || s_wren || s_done) act++;
    end
    chk(name, act, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [5:0] preq;
    int eidx, op, found;
    rst = 1'b1;
    s_draw = 1'b0; s_preset = 6'd0; b_draw = 1'b0; b_preset = 6'd0;
    bd_we = 1'b0; bd_addr = 2'd0; bd_data = 4'd0;
    for (int j = 0; j < 3; j++) shadow[j] = 4'd0;

    lt[0] = '{req: 6'b001000, idx: 3};
    lt[1] = '{req: 6'b000101, idx: 0};
    lt[2] = '{req: 6'b110000, idx: 4};
    lt[3] = '{req: 6'b100000, idx: 5};
    st[0] = '{r0: 4'b1000, r1: 4'b0001, r2: 4'b0110, ones: 16, first_on: 1'b1, last_on: 1'b0};
    st[1] = '{r0: 4'b1111, r1: 4'b1111, r2: 4'b1111, ones: 48, first_on: 1'b1, last_on: 1'b1};
    st[2] = '{r0: 4'b0000, r1: 4'b0000, r2: 4'b0000, ones: 0,  first_on: 1'b0, last_on: 1'b0};
    st[3] = '{r0: 4'b0101, r1: 4'b1010, r2: 4'b0011, ones: 24, first_on: 1'b0, last_on: 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_s_busy", s_busy, 0);      chk("rst_s_done", s_done, 0);
    chk("rst_s_plot", s_plot, 0);      chk("rst_s_wren", s_wren, 0);
    chk("rst_s_ram_addr", s_ram_addr, 0); chk("rst_s_pat_addr", s_pat_addr, 0);
    chk("rst_s_pix_x", s_pix_x, 0);    chk("rst_s_pix_y", s_pix_y, 0);
    chk("rst_s_pix_on", s_pix_on, 0);
    chk("rst_b_busy", b_busy, 0);      chk("rst_b_done", b_done, 0);
    chk("rst_b_plot", b_plot, 0);      chk("rst_b_wren", b_wren, 0);
    chk("rst_b_ram_addr", b_ram_addr, 0); chk("rst_b_pat_addr", b_pat_addr, 0);
    chk("rst_b_pix_x", b_pix_x, 0);    chk("rst_b_pix_y", b_pix_y, 0);

    // Default-size preset load
    @(negedge clk);
    b_preset = 6'b001000;
    run_big(100);
    chk("big_writes", wr_n, 30);
    chk("big_latency", cyc, 33);
    chk("big_busy_cycles", nb, 31);
    found = 0;
    for (int j = 0; j < 30 && j < wr_n; j++)
      if (wa[j] != j || wd[j] != rom_b(3, j)) found++;
    chk("big_row_data", found, 0);

    // Preset selection table
    for (int i = 0; i < 4; i++) begin
      pulse_small(lt[i].req, 1'b0);
      run_small(100, 0, 6'd0, 1'b0);
      check_load_small($sformatf("load%0d", i), lt[i].idx);
    end

    // Scan table
    for (int i = 0; i < 4; i++) begin
      set_rows(st[i].r0, st[i].r1, st[i].r2);
      pulse_small(6'd0, 1'b1);
      run_small(200, 0, 6'd0, 1'b0);
      check_scan($sformatf("scan%0d", i));
      found = 0;
      for (int j = 0; j < px_n && j < 64; j++) if (aon[j]) found++;
      chk($sformatf("scan%0d_table_ones", i), found, st[i].ones);
      chk($sformatf("scan%0d_first_on", i), aon[0], st[i].first_on);
      chk($sformatf("scan%0d_last_on", i), aon[47], st[i].last_on);
      if (i == 0) begin
        chk("order_p1", ax[1] * 8 + ay[1], 8);
        chk("order_p2", ax[2] * 8 + ay[2], 1);
        chk("order_p3", ax[3] * 8 + ay[3], 9);
        chk("order_p4", ax[4] * 8 + ay[4], 16);
        chk("order_p4_on", aon[4], 0);
        chk("order_last", ax[47] * 8 + ay[47], 61);
      end
    end

    // Preset and draw in the same cycle: load preset 0, then scan, then nothing
    set_rows(4'h0, 4'h0, 4'h0);
    pulse_small(6'b000101, 1'b1);
    run_small(100, 0, 6'd0, 1'b0);
    check_load_small("combo_load", 0);
    run_small(200, 0, 6'd0, 1'b0);
    check_scan("combo_scan");
    idle_quiet("combo_idle_after", 10);

    // Preset and draw arriving mid-scan
    set_rows(4'b1010, 4'b0101, 4'b1100);
    pulse_small(6'd0, 1'b1);
    run_small(200, 20, 6'b010000, 1'b1);
    check_scan("mid_scan");
    run_small(100, 0, 6'd0, 1'b0);
    check_load_small("mid_load", 4);
    run_small(200, 0, 6'd0, 1'b0);
    check_scan("mid_rescan");
    idle_quiet("mid_idle_after", 10);

    // Reset while plotting row 1
    pulse_small(6'd0, 1'b1);
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      s_draw = 1'b0;
      if (s_plot && s_pix_y >= 3'd2) begin found = 1; break; end
    end
    chk("rst_mid_row1_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_plot", s_plot, 0);
    chk("rst_mid_busy", s_busy, 0);
    chk("rst_mid_pix", s_pix_x * 8 + s_pix_y, 0);
    rst = 1'b0;
    pulse_small(6'd0, 1'b1);
    run_small(200, 0, 6'd0, 1'b0);
    check_scan("post_reset_scan");

    // Randomized operations
    for (int it = 0; it < 12; it++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        set_rows(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        pulse_small(6'd0, 1'b1);
        run_small(200, 0, 6'd0, 1'b0);
        check_scan($sformatf("rand%0d_scan", it));
      end else begin
        preq = 6'($urandom_range(1, 63));
        eidx = -1;
        for (int b = 5; b >= 0; b--) if (preq[b]) eidx = b;
        pulse_small(preq, op == 2);
        run_small(100, 0, 6'd0, 1'b0);
        check_load_small($sformatf("rand%0d_load", it), eidx);
        if (op == 2) begin
          run_small(200, 0, 6'd0, 1'b0);
          check_scan($sformatf("rand%0d_scan", it));
        end
        idle_quiet($sformatf("rand%0d_idle", it), 3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
